// File: rtl/encode_mul_pipe_acc.sv
// encode_mul_pipe_acc: parametrised pipelined multiplier with optional accumulate (MAC) and
// Q-format output scaling. It serves the ADPCM predictor sums in place of a separate multiplier
// followed by an adder.
//
// Pipeline
//   stage 1             registers operands, mode bits and acc controls
//   stage 2             registers the (A_W+1)x(B_W+1) signed product, kept to A_W+B_W bits
//   stage 3..NUM_STAGE-1  pure delay
//   stage NUM_STAGE     accumulate, scale, overflow detect; drives p/ovf/out_valid
//
// Ports
//   clk, reset_n         clock, synchronous active-low reset (wins over ce)
//   ce                   clock enable; 0 freezes every register, including the accumulator
//   in_valid, a, b       input token
//   a_signed, b_signed   per-operand two's complement select
//   acc_en, acc_clr      accumulate / clear-before-add (acc_clr alone clears when in_valid=0)
//   out_valid, p, ovf    result pulse, scaled result, out-of-range flag
//
// Build option: ENCODE_MUL_ROUND_SAT_EN adds round-half-up before the shift and saturation on
// overflow. Without it the result truncates toward -inf and wraps.
module encode_mul_pipe_acc #(
  parameter int unsigned A_W       = 16,
  parameter int unsigned B_W       = 16,
  parameter int unsigned P_W       = 32,
  parameter int unsigned SHIFT     = 0,
  parameter int unsigned GUARD     = 8,
  parameter int unsigned NUM_STAGE = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           ce,
  input  logic           in_valid,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  input  logic           a_signed,
  input  logic           b_signed,
  input  logic           acc_en,
  input  logic           acc_clr,
  output logic           out_valid,
  output logic [P_W-1:0] p,
  output logic           ovf
);

  localparam int unsigned M_W   = A_W + B_W;
  localparam int unsigned ACC_W = M_W + GUARD;
  // Scaling width: one bit above both ACC_W and P_W so rounding cannot carry out and the
  // overflow slices below are never empty.
  localparam int unsigned X_W   = (ACC_W > P_W) ? ACC_W + 1 : P_W + 1;
  // Delay-line depth covering stages 2..NUM_STAGE-1 (at least 1 for NUM_STAGE >= 3).
  localparam int          D     = int'(NUM_STAGE) - 2;

`ifdef ENCODE_MUL_ROUND_SAT_EN
  localparam logic [X_W-1:0] RND  = (X_W'(1) << SHIFT) >> 1;
  localparam logic [P_W-1:0] SMAX = {1'b0, {(P_W-1){1'b1}}};
  localparam logic [P_W-1:0] SMIN = {1'b1, {(P_W-1){1'b0}}};
  localparam logic [P_W-1:0] UMAX = '1;
`endif

  // Stage 1
  logic           s1_v_q, s1_en_q, s1_clr_q, s1_as_q, s1_bs_q;
  logic [A_W-1:0] s1_a_q;
  logic [B_W-1:0] s1_b_q;

  // Stages 2..NUM_STAGE-1
  logic [D-1:0]   dl_v_q, dl_en_q, dl_clr_q, dl_rs_q;
  logic [M_W-1:0] dl_p_q [D];

  // Final stage state
  logic             out_valid_q, ovf_q;
  logic [P_W-1:0]   p_q;
  logic [ACC_W-1:0] acc_q;

  // Product from stage 1 registers
  logic signed [A_W:0] op_a;
  logic signed [B_W:0] op_b;
  logic [M_W-1:0]      prod;

  always_comb begin
    op_a = $signed({s1_as_q & s1_a_q[A_W-1], s1_a_q});
    op_b = $signed({s1_bs_q & s1_b_q[B_W-1], s1_b_q});
    // Low M_W bits of the signed product; the full range of every mode fits in M_W bits.
    prod = M_W'(op_a * op_b);
  end

  // Final stage combinational path
  logic             fin_v, fin_en, fin_clr, fin_rs;
  logic [M_W-1:0]   fin_p;
  logic [ACC_W-1:0] prod_ext, r, acc_d;
  logic [X_W-1:0]   rx, sx;
  logic [P_W-1:0]   p_d;
  logic             ovf_d;

  always_comb begin
    fin_v   = dl_v_q[D-1];
    fin_en  = dl_en_q[D-1];
    fin_clr = dl_clr_q[D-1];
    fin_rs  = dl_rs_q[D-1];
    fin_p   = dl_p_q[D-1];

    prod_ext           = {ACC_W{fin_rs & fin_p[M_W-1]}};
    prod_ext[M_W-1:0]  = fin_p;

    if (fin_en) begin
      r = (fin_clr ? '0 : acc_q) + prod_ext;
    end else begin
      r = prod_ext;
    end

    rx            = {X_W{fin_rs & r[ACC_W-1]}};
    rx[ACC_W-1:0] = r;
`ifdef ENCODE_MUL_ROUND_SAT_EN
    rx = rx + RND;
`endif

    if (fin_rs) begin
      sx    = $unsigned($signed(rx) >>> SHIFT);
      // In range iff every bit from the P_W sign bit upward matches.
      ovf_d = !((&sx[X_W-1:P_W-1]) | ~(|sx[X_W-1:P_W-1]));
    end else begin
      sx    = rx >> SHIFT;
      ovf_d = |sx[X_W-1:P_W];
    end

    p_d = sx[P_W-1:0];
`ifdef ENCODE_MUL_ROUND_SAT_EN
    if (ovf_d) begin
      if (!fin_rs) begin
        p_d = UMAX;
      end else if (sx[X_W-1]) begin
        p_d = SMIN;
      end else begin
        p_d = SMAX;
      end
    end
`endif

    // Accumulator holds the unrounded sum; a bare acc_clr bubble clears it.
    acc_d = acc_q;
    if (fin_v && fin_en) begin
      acc_d = r;
    end else if (!fin_v && fin_clr) begin
      acc_d = '0;
    end
  end

  // Control and result state: reset clears tokens, outputs and accumulator regardless of ce.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_v_q      <= 1'b0;
      s1_en_q     <= 1'b0;
      s1_clr_q    <= 1'b0;
      dl_v_q      <= '0;
      dl_en_q     <= '0;
      dl_clr_q    <= '0;
      out_valid_q <= 1'b0;
      p_q         <= '0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
    end else if (ce) begin
      s1_v_q      <= in_valid;
      s1_en_q     <= acc_en;
      s1_clr_q    <= acc_clr;
      dl_v_q[0]   <= s1_v_q;
      dl_en_q[0]  <= s1_en_q;
      dl_clr_q[0] <= s1_clr_q;
      for (int i = 1; i < D; i++) begin
        dl_v_q[i]   <= dl_v_q[i-1];
        dl_en_q[i]  <= dl_en_q[i-1];
        dl_clr_q[i] <= dl_clr_q[i-1];
      end
      out_valid_q <= fin_v;
      if (fin_v) begin
        p_q   <= p_d;
        ovf_q <= ovf_d;
      end
      acc_q <= acc_d;
    end
  end

  // Datapath: only meaningful under a valid bit, so no reset.
  always_ff @(posedge clk) begin
    if (ce) begin
      s1_a_q     <= a;
      s1_b_q     <= b;
      s1_as_q    <= a_signed;
      s1_bs_q    <= b_signed;
      dl_p_q[0]  <= prod;
      dl_rs_q[0] <= s1_as_q | s1_bs_q;
      for (int i = 1; i < D; i++) begin
        dl_p_q[i]  <= dl_p_q[i-1];
        dl_rs_q[i] <= dl_rs_q[i-1];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign p         = p_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_encode_mul_pipe_acc.sv
// Bench for encode_mul_pipe_acc: a default instance (32-bit out, no shift, 4 stages) and a
// Q15 instance (16-bit out, SHIFT=15, 3 stages) share one input stream. Expected results come
// from an arithmetic reference model and are consumed in order whenever out_valid && ce.
module tb_encode_mul_pipe_acc;

  logic        clk = 1'b0;
  logic        reset_n, ce, in_valid, a_signed, b_signed, acc_en, acc_clr;
  logic [15:0] a, b;
  logic        ov1, ov2, of1, of2;
  logic [31:0] p1;
  logic [15:0] p2;

  always #5 clk = ~clk;

  encode_mul_pipe_acc dut1 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
    .a_signed(a_signed), .b_signed(b_signed), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(ov1), .p(p1), .ovf(of1)
  );

  encode_mul_pipe_acc #(.P_W(16), .SHIFT(15), .NUM_STAGE(3)) dut2 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
    .a_signed(a_signed), .b_signed(b_signed), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(ov2), .p(p2), .ovf(of2)
  );

  typedef struct { longint p; bit o; } exp_t;

  localparam longint ONE    = 1;
  localparam longint MASK40 = (ONE << 40) - 1;

  int     total = 0;
  int     bad   = 0;
  exp_t   q1[$];
  exp_t   q2[$];
  exp_t   e1, e2;
  longint acc_m[2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
    end
  endtask

  // Arithmetic reference: integer product, 40-bit wrapping accumulator, floor shift, range check.
  function automatic exp_t model_tok(input int c, input int pw, input int sh,
                                     input logic [15:0] ia, input logic [15:0] ib,
                                     input bit ias, input bit ibs, input bit ien, input bit iclr);
    longint av, bv, prod, r, s, hi, lo;
    bit     rs;
    exp_t   e;
    av   = ias ? longint'($signed(ia)) : longint'(ia);
    bv   = ibs ? longint'($signed(ib)) : longint'(ib);
    prod = av * bv;
    rs   = ias | ibs;
    if (ien) begin
      r        = ((iclr ? 0 : acc_m[c]) + prod) & MASK40;
      acc_m[c] = r;
    end else begin
      r = prod & MASK40;
    end
    if (rs && r[39]) r = r - (ONE << 40);
`ifdef ENCODE_MUL_ROUND_SAT_EN
    if (sh > 0) r = r + (ONE << (sh - 1));
`endif
    s = r >>> sh;
    if (rs) begin
      hi = (ONE << (pw - 1)) - 1;
      lo = -(ONE << (pw - 1));
    end else begin
      hi = (ONE << pw) - 1;
      lo = 0;
    end
    e.o = (s > hi) || (s < lo);
`ifdef ENCODE_MUL_ROUND_SAT_EN
    if (s > hi) s = hi;
    if (s < lo) s = lo;
`endif
    e.p = s & ((ONE << pw) - 1);
    return e;
  endfunction

  task automatic drive(input bit v, input logic [15:0] ia, input logic [15:0] ib,
                       input bit ias, input bit ibs, input bit ien, input bit iclr, input bit ice);
    in_valid = v;  a = ia;  b = ib;  a_signed = ias;  b_signed = ibs;
    acc_en = ien;  acc_clr = iclr;  ce = ice;
    if (ice) begin
      if (v) begin
        q1.push_back(model_tok(0, 32, 0, ia, ib, ias, ibs, ien, iclr));
        q2.push_back(model_tok(1, 16, 15, ia, ib, ias, ibs, ien, iclr));
      end else if (iclr) begin
        acc_m[0] = 0;
        acc_m[1] = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset(input bit ice);
    reset_n = 1'b0;  ce = ice;  in_valid = 1'b0;  acc_clr = 1'b0;  acc_en = 1'b0;
    q1.delete();
    q2.delete();
    acc_m[0] = 0;
    acc_m[1] = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && (q1.size() + q2.size()) != 0; i++) idle();
    chk("drain pending results", 64'(q1.size() + q2.size()), 64'd0);
  endtask

  // Consumer: a result is taken at the edge where out_valid and ce are both high.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && ce === 1'b1) begin
      if (ov1 === 1'b1) begin
        chk("dut1 result expected", 64'(q1.size() > 0), 64'd1);
        if (q1.size() > 0) begin
          e1 = q1.pop_front();
          chk("dut1 p", 64'(p1), e1.p);
          chk("dut1 ovf", 64'(of1), 64'(e1.o));
        end
      end
      if (ov2 === 1'b1) begin
        chk("dut2 result expected", 64'(q2.size() > 0), 64'd1);
        if (q2.size() > 0) begin
          e2 = q2.pop_front();
          chk("dut2 p", 64'(p2), e2.p);
          chk("dut2 ovf", 64'(of2), 64'(e2.o));
        end
      end
    end
  end

  initial begin
    int          cnt;
    logic [15:0] ra, rb;
    reset_n = 1'b0;  ce = 1'b0;  in_valid = 1'b0;  a = '0;  b = '0;
    a_signed = 1'b0;  b_signed = 1'b0;  acc_en = 1'b0;  acc_clr = 1'b0;
    acc_m[0] = 0;
    acc_m[1] = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("reset out_valid1", 64'(ov1), 64'd0);
    chk("reset p1", 64'(p1), 64'd0);
    chk("reset ovf1", 64'(of1), 64'd0);
    chk("reset out_valid2", 64'(ov2), 64'd0);
    chk("reset p2", 64'(p2), 64'd0);

    // -3 x 7 signed: single pulse exactly three edges after acceptance
    drive(1'b1, 16'hFFFD, 16'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t1 latency edge0", 64'(ov1), 64'd0);
    idle();
    chk("t1 latency edge1", 64'(ov1), 64'd0);
    idle();
    chk("t1 latency edge2", 64'(ov1), 64'd0);
    idle();
    chk("t1 latency edge3", 64'(ov1), 64'd1);
    chk("t1 p", 64'(p1), 64'hFFFF_FFEB);
    idle();
    chk("t1 single pulse", 64'(ov1), 64'd0);
    drain();

    // 0xFFFF squared, unsigned then signed
    drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    drain();

    // Back-to-back tokens with a two-cycle stall after the second
    drive(1'b1, 16'd2, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 16'd4, 16'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 16'd6, 16'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'd6, 16'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'd6, 16'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    // MAC: 100x100 four times, then a plain 1x1, then 0x0 accumulate reads the sum back
    drive(1'b1, 16'd100, 16'd100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 16'd100, 16'd100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 16'd1, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    drain();

    // Q15 boundary: -32768 squared overflows; 3 x 16384 exercises rounding
    drive(1'b1, 16'h8000, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 16'd3, 16'd16384, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    // Reset under ce=0 drops in-flight tokens
    drive(1'b1, 16'd1, 16'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 16'd2, 16'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 16'd3, 16'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    do_reset(1'b0);
    chk("t6 out_valid1 after reset", 64'(ov1), 64'd0);
    chk("t6 p1 after reset", 64'(p1), 64'd0);
    chk("t6 ovf1 after reset", 64'(of1), 64'd0);
    chk("t6 p2 after reset", 64'(p2), 64'd0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      idle();
      cnt += int'(ov1);
    end
    chk("t6 dropped tokens stay dropped", 64'(cnt), 64'd0);
    drive(1'b1, 16'd5, 16'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    drain();

    // Random mix of modes, MAC, bare clears and stalls
    for (int i = 0; i < 400; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 5))
        0: ra = 16'h8000;
        1: rb = 16'h7FFF;
        2: begin ra = 16'hFFFF; rb = 16'hFFFF; end
        default: ;
      endcase
      drive($urandom_range(0, 3) != 0, ra, rb, 1'($urandom), 1'($urandom),
            1'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 6) != 0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
